// File: rtl/app_pkg.sv
// app_pkg: shared constants and types for the line-echo application endpoint.
//   CHAR_CR / CHAR_LF   : line terminator handling
//   CHAR_LC_A/CHAR_LC_Z : lowercase ASCII bounds used by the optional
//                         APP_UPPERCASE_EN push-side conversion
//   state_t             : FILL / DRAIN / DRAIN_LF
//   obyte_t             : output holding register (valid + byte)
package app_pkg;

  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_LF   = 8'h0A;
  localparam logic [7:0] CHAR_LC_A = 8'h61;
  localparam logic [7:0] CHAR_LC_Z = 8'h7A;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    DRAIN    = 2'd1,
    DRAIN_LF = 2'd2
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } obyte_t;

  // Lowercase ASCII to uppercase; everything else unchanged.
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= CHAR_LC_A && b <= CHAR_LC_Z) return b - 8'h20;
    return b;
  endfunction

endpackage

// File: rtl/app_fifo.sv
// app_fifo: synchronous single-clock FIFO, combinational head (no output reg).
//   clk_i, rstn_i : clock, synchronous active-low reset
//   push, wdata   : write strobe / data (ignored by caller when full)
//   pop, rdata    : read strobe / current head (valid when !empty)
//   full, empty   : status
//   count         : occupancy, clog2(DEPTH)+1 bits
module app_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wptr, rptr;

  assign rdata = mem[rptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointers are exactly AW bits so they wrap naturally at DEPTH.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/app_line_echo.sv
// app_line_echo: application endpoint of the usb_cdc byte stream.
// Collects host bytes into a line buffer, then echoes the line back when a CR
// arrives (followed by an appended LF) or when the buffer fills (no LF).
// Build option: APP_UPPERCASE_EN converts a..z to A..Z at buffer push.
//   clk_i, rstn_i           : 12 MHz app clock, synchronous active-low reset
//   out_data_i/valid_i/ready_o : host->device stream (this block is sink)
//   in_data_o/valid_o/ready_i  : device->host stream (this block is source)
//   sleep_o                 : registered idle indication after IDLE_CYCLES
module app_line_echo
  import app_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int IDLE_CYCLES = 1200000
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  output logic       sleep_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [AW:0]   LAST_CNT = (AW+1)'(DEPTH - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

  state_t        state, state_nxt;
  logic          lf_pend, lf_pend_nxt;
  obyte_t        ob, ob_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt;

  logic          push, pop, full, empty;
  logic [7:0]    wdata, head;
  logic [AW:0]   count;
  logic          out_xfer, in_xfer, ob_free, idle_clr;

  app_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef APP_UPPERCASE_EN
  assign wdata = to_upper(out_data_i);
`else
  assign wdata = out_data_i;
`endif

  assign out_ready_o = (state == FILL) && !full;
  assign in_valid_o  = ob.vld;
  assign in_data_o   = ob.data;
  assign out_xfer    = out_valid_i && out_ready_o;
  assign in_xfer     = ob.vld && in_ready_i;
  // Holding register can take a new byte this edge (empty or draining now).
  assign ob_free     = !ob.vld || in_ready_i;

  always_comb begin
    state_nxt   = state;
    lf_pend_nxt = lf_pend;
    ob_nxt      = ob;
    push        = 1'b0;
    pop         = 1'b0;
    if (in_xfer) ob_nxt.vld = 1'b0;
    case (state)
      FILL: begin
        // A pending LF may still sit in ob here; FILL keeps accepting.
        if (out_xfer) begin
          push = 1'b1;
          if (out_data_i == CHAR_CR || count == LAST_CNT) begin
            state_nxt   = DRAIN;
            lf_pend_nxt = (out_data_i == CHAR_CR);
          end
        end
      end
      DRAIN: begin
        if (ob_free) begin
          if (!empty) begin
            pop    = 1'b1;
            ob_nxt = '{vld: 1'b1, data: head};
          end else begin
            state_nxt = lf_pend ? DRAIN_LF : FILL;
          end
        end
      end
      DRAIN_LF: begin
        if (ob_free) begin
          ob_nxt      = '{vld: 1'b1, data: CHAR_LF};
          lf_pend_nxt = 1'b0;
          state_nxt   = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Idle tracking: anything in flight or buffered holds the counter at zero.
  assign idle_clr = out_xfer || in_xfer || ob.vld || (state != FILL) || !empty;
  assign idle_nxt = idle_clr ? '0 :
                    (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state    <= FILL;
      lf_pend  <= 1'b0;
      ob       <= '0;
      idle_cnt <= '0;
      sleep_o  <= 1'b0;
    end else begin
      state    <= state_nxt;
      lf_pend  <= lf_pend_nxt;
      ob       <= ob_nxt;
      idle_cnt <= idle_nxt;
      sleep_o  <= (idle_nxt == IDLE_MAX);
    end
  end

endmodule
